// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter state types
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    // ARB_ prefix keeps these distinct from the ramstate_t literals
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin priority encoder, first active index at or after rr_ptr
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW = 2
) (
    input  logic [N_REQ-1:0] active,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    gid,
    output logic             any
);
    assign any = |active;
    always_comb begin
        gid = '0;
        for (int o = N_REQ - 1; o >= 0; o--)
            if (active[(int'(rr_ptr) + o) % N_REQ]) gid = IW'((int'(rr_ptr) + o) % N_REQ);
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port, one transaction in flight with timeout
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req_ren,
    input  logic [N_REQ-1:0]    req_wen,
    input  logic [N_REQ*32-1:0] req_addr,
    input  logic [N_REQ*32-1:0] req_store,
    output logic [N_REQ-1:0]    req_done,
    output logic                req_err,
    output word_t               req_load,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    arb_state_t state_q, state_d;
    logic [IW-1:0] gid_q, gid_d, ptr_q, ptr_d, pick;
    word_t addr_q, addr_d, store_q, store_d, load_q, load_d;
    logic wr_q, wr_d, err_q, err_d, any;
    logic [7:0] cnt_q, cnt_d;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .active(req_ren | req_wen),
        .rr_ptr(ptr_q),
        .gid(pick),
        .any(any)
    );

    always_comb begin
        state_d = state_q;
        gid_d = gid_q;
        ptr_d = ptr_q;
        addr_d = addr_q;
        store_d = store_q;
        load_d = load_q;
        wr_d = wr_q;
        err_d = err_q;
        cnt_d = cnt_q;
        case (state_q)
            ARB_IDLE: if (any) begin
                gid_d = pick;
                ptr_d = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
                addr_d = {req_addr[int'(pick)*32+2 +: 30], 2'b00};
                store_d = req_store[int'(pick)*32 +: 32];
                wr_d = req_wen[pick];
                load_d = '0;
                err_d = 1'b0;
                cnt_d = '0;
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (ramstate == ACCESS) begin
                    load_d = wr_q ? '0 : ramload;
                    err_d = 1'b0;
                    state_d = ARB_RESP;
                end else if (ramstate == ERROR || cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    state_d = ARB_RESP;
                end else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            gid_q <= '0;
            ptr_q <= '0;
            addr_q <= '0;
            store_q <= '0;
            load_q <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
            addr_q <= addr_d;
            store_q <= store_d;
            load_q <= load_d;
            wr_q <= wr_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // RAM side is driven only from latched registers
    assign ramREN = state_q == ARB_ACCESS && !wr_q;
    assign ramWEN = state_q == ARB_ACCESS && wr_q;
    assign ramaddr = state_q == ARB_ACCESS ? addr_q : '0;
    assign ramstore = state_q == ARB_ACCESS ? store_q : '0;
    assign req_done = state_q == ARB_RESP ? N_REQ'(1) << gid_q : '0;
    assign req_err = state_q == ARB_RESP && err_q;
    assign req_load = state_q == ARB_RESP ? load_q : '0;
endmodule
